seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares the single hex-to-seven-segment decoder across NUM_DIGITS common-anode digits of the calculator display. It holds a tear-free shadow copy of the value to be shown and steps through the digits. For each digit it drives that digit's nibble to the decoder inputs and asserts that digit's anode, with a dead-time gap between digits to prevent ghosting. It sits between the ALU result/operand register and the decoder plus the board's anode pins.

Parameters:
NUM_DIGITS, 4, number of display digits; must be at least 2.
DATA_W, 4*NUM_DIGITS, width of the displayed value; fixed at 4 bits per digit.
REFRESH_DIV, 50000, clock cycles per digit slot; must be at least DEAD_CYCLES+1.
DEAD_CYCLES, 500, cycles at the start of each slot during which all anodes are off.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  scan enable; low blanks the display and freezes the scan
load  in  1  one-cycle request to display value
value  in  DATA_W  value sampled when load=1
load_ack  out  1  one-cycle pulse when the shadow register takes the pending value
nibble  out  4  current digit's nibble to the decoder inputs {w,x,y,z}; bit 3 = w
an_n  out  NUM_DIGITS  active-low anode enables; bit i = digit i; digit 0 is least significant
digit_sel  out  $clog2(NUM_DIGITS)  index of the digit currently in its slot
frame_tick  out  1  one-cycle pulse at the end of each full scan of all digits

Behaviour:
- Reset (synchronous, active-high, evaluated at the posedge clk): the following take these values on the next edge, and reset overrides all other activity, including reset applied mid-frame or mid-load.
  - prescaler=0, digit_sel=0, state=DEAD.
  - shadow=0, pending=0, pending_val=0.
  - an_n=all ones, nibble=0, load_ack=0, frame_tick=0.
- Prescaler: counts 0..REFRESH_DIV-1. The slot ends at REFRESH_DIV-1.
- State machine, two states:
  - DEAD: active while prescaler < DEAD_CYCLES. an_n is all ones.
  - DRIVE: active for the rest of the slot. an_n has only bit digit_sel low.
- Slot end: prescaler wraps to 0, state returns to DEAD, and digit_sel increments. digit_sel wraps from NUM_DIGITS-1 to 0.
- Frame end (slot end with digit_sel=NUM_DIGITS-1):
  - frame_tick pulses for 1 cycle.
  - If pending=1: shadow<=pending_val, pending<=0, and load_ack pulses in the same cycle.
- Tear-free update: the shadow register changes only at a frame boundary.
- load handling:
  - load=1 sets pending<=1 and pending_val<=value.
  - A load while pending is already set overwrites pending_val; the latest value wins and only one load_ack is issued.
  - A load in the same cycle as a frame-end transfer takes the new value as pending. The transfer uses the old pending_val, and pending stays 1.
- nibble = shadow[4*digit_sel+3 : 4*digit_sel].
  - nibble updates at the slot start, i.e. during DEAD, so the decoder settles before the anode turns on.
- Output timing: all outputs are registered, with a 1-cycle latency from the internal counter state.
- en=0:
  - an_n goes all ones on the next edge.
  - prescaler, digit_sel and state hold their values.
  - load is still accepted, but no transfer occurs because frames do not advance.
- When en returns to 1, the scan resumes from the held prescaler value.

Optional Feature:
Macro SEG_SCAN_LZB_EN enables leading-zero blanking.
- Defined: any digit i>0 whose nibble, and the nibbles of all digits above it, are all zero keeps its anode off (an_n[i]=1) during DRIVE. Digit 0 is never blanked.
- Undefined: all digits are driven, and the blanking logic is absent.

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum {DEAD, DRIVE};
  - a function computing the digit_sel width from NUM_DIGITS;
  - the constant NIBBLE_W=4.
- Sub-module seg_scan_prescaler: slot counter with terminal-count and dead-window flags, parameterised by REFRESH_DIV and DEAD_CYCLES.
- The decoder is instantiated outside this block. It is not a child of seg_scan_ctrl.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1 unless stated):
- Reset then run 16 cycles: an_n follows the sequence 1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3. frame_tick pulses once at cycle 16. nibble=0 throughout.
- load value=16'hA3C5 mid-frame: nibble and an_n are unchanged until the frame end, then load_ack pulses once. The next frame shows nibbles 5, C, 3, A on digits 0–3.
- Two loads in the same frame, 16'h1111 then 16'h2222: one load_ack only, and the next frame shows 2222.
- reset asserted while in DRIVE of digit 2 with pending=1: next cycle an_n=1111, digit_sel=0, pending=0, and no load_ack follows.
- en=0 for 10 cycles during digit 1: an_n=1111 and digit_sel=1 hold. After en=1, digit 1 completes its remaining slot cycles.
- SEG_SCAN_LZB_EN defined, value 16'h0040: digits 3 and 2 stay off, digit 1 shows 4, digit 0 shows 0. With value 16'h0000, only digit 0 is driven.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the seven-segment scan controller.
//   NIBBLE_W       bits per displayed digit
//   seg_state_t    slot state encoding (DEAD / DRIVE)
//   sel_width()    width of the digit index for a given digit count
package seg_scan_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [0:0] seg_state_t;
  localparam seg_state_t DEAD  = 1'b0;
  localparam seg_state_t DRIVE = 1'b1;

  function automatic int unsigned sel_width(input int unsigned num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// seg_scan_prescaler: per-digit slot counter, 0..REFRESH_DIV-1, frozen while en_i is low.
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset (count returns to 0)
//   en_i    count enable
//   tc_o    terminal count, high on the last cycle of a slot
//   dead_o  high while the count is inside the leading dead window
module seg_scan_prescaler #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tc_o,
  output logic dead_o
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0] count_d, count_q;

  assign tc_o   = (count_q == CNT_LAST);
  assign dead_o = (count_q < DEAD_END);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-anode digits
// sharing one hex-to-seven-segment decoder. A shadow copy of the displayed value is only
// replaced at a frame boundary so a frame never mixes old and new digits.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   en           scan enable; low blanks the anodes and freezes the scan
//   load, value  request to display value (latest request wins)
//   load_ack     pulse when the shadow register takes the pending value
//   nibble       current digit's nibble to the decoder {w,x,y,z}
//   an_n         active-low anode enables, bit i = digit i
//   digit_sel    index of the digit currently in its slot
//   frame_tick   pulse at the end of each full scan
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = NIBBLE_W * NUM_DIGITS,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 500,
  parameter int unsigned SEL_W       = sel_width(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  output logic                  load_ack,
  output logic [NIBBLE_W-1:0]   nibble,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [SEL_W-1:0]      digit_sel,
  output logic                  frame_tick
);

  logic       tc;
  logic       dead;
  seg_state_t state;

  seg_scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en),
    .tc_o   (tc),
    .dead_o (dead)
  );

  // State is a pure decode of the prescaler window; the prescaler holds it across en=0.
  assign state = dead ? DEAD : DRIVE;

  logic [SEL_W-1:0]      dsel_d, dsel_q;
  logic [DATA_W-1:0]     shadow_d, shadow_q;
  logic                  pending_d, pending_q;
  logic [DATA_W-1:0]     pending_val_d, pending_val_q;
  logic [NUM_DIGITS-1:0] an_n_d, an_n_q;
  logic [NIBBLE_W-1:0]   nibble_d, nibble_q;
  logic                  load_ack_d, load_ack_q;
  logic                  frame_tick_d, frame_tick_q;
  logic [SEL_W-1:0]      digit_sel_d, digit_sel_q;
  logic [NUM_DIGITS-1:0] blank;
  logic                  last_digit;
  logic                  frame_end;

`ifdef SEG_SCAN_LZB_EN
  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (shadow_q[NIBBLE_W*i +: NIBBLE_W] == '0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    last_digit = (dsel_q == SEL_W'(NUM_DIGITS - 1));
    frame_end  = en && tc && last_digit;

    dsel_d = dsel_q;
    if (en && tc) begin
      dsel_d = last_digit ? '0 : dsel_q + 1'b1;
    end

    shadow_d      = shadow_q;
    pending_d     = pending_q;
    pending_val_d = pending_val_q;
    load_ack_d    = 1'b0;
    if (frame_end && pending_q) begin
      shadow_d   = pending_val_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
    // A load coinciding with a transfer stays pending; the transfer used the old value.
    if (load) begin
      pending_d     = 1'b1;
      pending_val_d = value;
    end

    frame_tick_d = frame_end;
    digit_sel_d  = dsel_q;
    // Nibble follows the digit index immediately, so it settles during the dead window.
    nibble_d     = shadow_q[NIBBLE_W*dsel_q +: NIBBLE_W];

    an_n_d = '1;
    if (en && (state == DRIVE)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((dsel_q == SEL_W'(i)) && !blank[i]) begin
          an_n_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsel_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      pending_val_q <= '0;
      an_n_q        <= '1;
      nibble_q      <= '0;
      load_ack_q    <= 1'b0;
      frame_tick_q  <= 1'b0;
      digit_sel_q   <= '0;
    end else begin
      dsel_q        <= dsel_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      pending_val_q <= pending_val_d;
      an_n_q        <= an_n_d;
      nibble_q      <= nibble_d;
      load_ack_q    <= load_ack_d;
      frame_tick_q  <= frame_tick_d;
      digit_sel_q   <= digit_sel_d;
    end
  end

  assign an_n       = an_n_q;
  assign nibble     = nibble_q;
  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;
  assign digit_sel  = digit_sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
// Honours SEG_SCAN_LZB_EN when the bundle is built with it.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        load_ack;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  int          checks = 0;
  int          errors = 0;
  int          k      = 0;   // enabled edges since reset release
  logic [15:0] disp   = '0;  // value the display should currently show

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .value      (value),
    .load_ack   (load_ack),
    .nibble     (nibble),
    .an_n       (an_n),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  // One enabled clock edge, then check every output against the slot schedule.
  task automatic tick_chk(input logic ack_exp);
    int         c;
    int         s;
    logic [3:0] exp_an;
    @(posedge clk);
    #1;
    k++;
    c      = (k - 1) % 4;
    s      = ((k - 1) / 4) % 4;
    exp_an = 4'hF;
    if (c != 0) begin
      exp_an[s] = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      if ((s > 0) && ((disp >> (4 * s)) == 16'h0)) exp_an = 4'hF;
`endif
    end
    chk("an_n", 32'(an_n), 32'(exp_an));
    chk("nibble", 32'(nibble), 32'(disp[4*s +: 4]));
    chk("digit_sel", 32'(digit_sel), 32'(s));
    chk("frame_tick", 32'(frame_tick), 32'(k % 16 == 0));
    chk("load_ack", 32'(load_ack), 32'(ack_exp));
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    tick_chk(1'b0);
    load  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_chk(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    load  = 1'b0;
    value = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_an_n", 32'(an_n), 32'h0000_000F);
    chk("rst_nibble", 32'(nibble), 32'h0);
    chk("rst_digit_sel", 32'(digit_sel), 32'h0);
    chk("rst_load_ack", 32'(load_ack), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    reset = 1'b0;

    // First frame: blank value, plain scan.
    ticks(16);

    // Mid-frame load: display unchanged until the frame end transfer.
    ticks(6);
    do_load(16'hA3C5);
    ticks(8);
    tick_chk(1'b1);
    disp = 16'hA3C5;
    ticks(16);

    // Two loads in one frame: latest wins, one acknowledge.
    ticks(1);
    do_load(16'h1111);
    ticks(4);
    do_load(16'h2222);
    ticks(8);
    tick_chk(1'b1);
    disp = 16'h2222;
    ticks(16);

    // Reset while driving digit 2 with a load pending.
    ticks(1);
    do_load(16'h7777);
    ticks(8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_an_n", 32'(an_n), 32'h0000_000F);
    chk("midrst_digit_sel", 32'(digit_sel), 32'h0);
    chk("midrst_load_ack", 32'(load_ack), 32'h0);
    chk("midrst_nibble", 32'(nibble), 32'h0);
    reset = 1'b0;
    k     = 0;
    disp  = '0;
    // A full frame follows with no acknowledge: the pending load was discarded.
    ticks(22);

    // Scan freeze during digit 1; a load is still accepted.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        load  = 1'b1;
        value = 16'h0040;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      chk("hold_an_n", 32'(an_n), 32'h0000_000F);
      chk("hold_digit_sel", 32'(digit_sel), 32'h1);
      chk("hold_frame_tick", 32'(frame_tick), 32'h0);
      chk("hold_load_ack", 32'(load_ack), 32'h0);
    end
    en = 1'b1;
    // Digit 1 finishes its remaining two drive cycles, then the frame completes.
    ticks(9);
    tick_chk(1'b1);
    disp = 16'h0040;
    ticks(16);

    // All-zero value: with blanking only digit 0 lights.
    ticks(1);
    do_load(16'h0000);
    ticks(13);
    tick_chk(1'b1);
    disp = 16'h0000;
    ticks(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
